// File: rtl/player_missile_ctrl.sv
// Player shot controller: launches a single missile from the cannon on a frame
// boundary, climbs it once per frame, and retires it on a hit or at the screen top.
module player_missile_ctrl #(
  parameter int Y_SPEED         = 8,
  parameter int X_OFFSET        = 28,
  parameter int MISSILE_HEIGHT  = 16,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fireKey,
  input  logic        plrHit,
  input  logic        missileHit,
  input  logic [10:0] playerTopLeftX,
  input  logic [10:0] playerTopLeftY,
  output logic [10:0] missileTopLeftX,
  output logic [10:0] missileTopLeftY,
  output logic        missileActive,
  output logic        shotFired,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam logic [10:0] X_OFF  = 11'(X_OFFSET);
  localparam logic [10:0] HEIGHT = 11'(MISSILE_HEIGHT);
  localparam logic [10:0] SPEED  = 11'(Y_SPEED);
  localparam logic [7:0]  CD_INIT = 8'(COOLDOWN_FRAMES);

  state_t      state, state_n;
  logic        fire_key_d;
  logic        fire_req, fire_req_n;
  logic [7:0]  counter, counter_n;
  logic [10:0] pos_x_n, pos_y_n;
  logic        shot_n;
  logic        fire_edge;

  assign fire_edge = fireKey & ~fire_key_d;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= IDLE;
      fire_key_d      <= 1'b0;
      fire_req        <= 1'b0;
      counter         <= 8'd0;
      missileTopLeftX <= 11'd0;
      missileTopLeftY <= 11'd0;
      missileActive   <= 1'b0;
      shotFired       <= 1'b0;
    end else begin
      state           <= state_n;
      fire_key_d      <= fireKey;
      fire_req        <= fire_req_n;
      counter         <= counter_n;
      missileTopLeftX <= pos_x_n;
      missileTopLeftY <= pos_y_n;
      missileActive   <= (state_n == FLYING);
      shotFired       <= shot_n;
    end
  end

  // Priority: plrHit, then missileHit, then frame-boundary movement/launch.
  always_comb begin
    state_n    = state;
    fire_req_n = fire_req;
    counter_n  = counter;
    pos_x_n    = missileTopLeftX;
    pos_y_n    = missileTopLeftY;
    shot_n     = 1'b0;

    if (plrHit) begin
      state_n    = IDLE;
      fire_req_n = 1'b0;
      counter_n  = 8'd0;
      pos_x_n    = 11'd0;
      pos_y_n    = 11'd0;
    end else begin
      case (state)
        IDLE: begin
          if (startOfFrame && (fire_req || fire_edge)) begin
            state_n    = FLYING;
            fire_req_n = 1'b0;
            shot_n     = 1'b1;
            pos_x_n    = playerTopLeftX + X_OFF;
            pos_y_n    = (playerTopLeftY < HEIGHT) ? 11'd0 : playerTopLeftY - HEIGHT;
          end else if (fire_edge) begin
            fire_req_n = 1'b1;
          end
        end
        FLYING: begin
          if (missileHit) begin
            state_n   = COOLDOWN;
            counter_n = CD_INIT;
          end else if (startOfFrame) begin
            if (missileTopLeftY < SPEED) begin
              state_n   = COOLDOWN;
              counter_n = CD_INIT;
            end else begin
              pos_y_n = missileTopLeftY - SPEED;
            end
          end
        end
        COOLDOWN: begin
          if (startOfFrame) begin
            if (counter <= 8'd1) state_n = IDLE;
            else counter_n = counter - 8'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: doc/player_missile_ctrl.md
# player_missile_ctrl

Player shot controller for the Space Invaders datapath, directly downstream of the player movement block. It takes the player's top-left position and the fire key, launches one missile from the player's cannon on a frame boundary, and moves it upward once per frame. It retires the missile on an alien/shield hit or when it leaves the top of the screen. Its outputs feed the missile drawing object, collision logic, and sound/score logic.

## Interface
Parameters:
- Y_SPEED, 8: pixels the missile rises per frame.
- X_OFFSET, 28: added to the player X to centre the missile on the cannon.
- MISSILE_HEIGHT, 16: missile sprite height in pixels; the launch Y is placed this far above the player top.
- COOLDOWN_FRAMES, 4: frames spent in COOLDOWN after a missile retires before the next launch is allowed.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse at the start of each frame.
- fireKey  in  1  fire key level, synchronous to clk.
- plrHit  in  1  player destroyed; aborts all activity.
- missileHit  in  1  missile collided with an alien or shield.
- playerTopLeftX  in  11  current player X.
- playerTopLeftY  in  11  current player Y.
- missileTopLeftX  out  11  missile X.
- missileTopLeftY  out  11  missile Y.
- missileActive  out  1  missile is in flight; gates drawing and collision.
- shotFired  out  1  one-cycle pulse when a missile launches.

## Operation
- Edge detect:
  - fireKey_d is registered every cycle; reset value 0.
  - fireEdge = fireKey & ~fireKey_d.
  - A key held through reset release therefore fires once.
- Pending request (fireReq):
  - fireEdge in IDLE sets fireReq.
  - fireReq clears on launch and on plrHit.
  - Edges outside IDLE are ignored and not latched.
- States: IDLE, FLYING, COOLDOWN. Reset state is IDLE.
- IDLE:
  - Launch condition: startOfFrame & (fireReq | fireEdge).
  - On launch, go to FLYING.
  - missileTopLeftX = playerTopLeftX + X_OFFSET, truncated to 11 bits.
  - missileTopLeftY = playerTopLeftY − MISSILE_HEIGHT, clamped to 0 if playerTopLeftY < MISSILE_HEIGHT.
  - shotFired = 1 for that one cycle.
- FLYING:
  - missileHit (any cycle) → COOLDOWN, counter ← COOLDOWN_FRAMES, Y unchanged.
  - Otherwise, on startOfFrame:
    - if Y < Y_SPEED → COOLDOWN, counter ← COOLDOWN_FRAMES, Y unchanged;
    - else Y ← Y − Y_SPEED.
  - X is constant in flight; it does not track the player.
- COOLDOWN:
  - On startOfFrame, if counter ≤ 1 → IDLE; else counter ← counter − 1.
  - COOLDOWN lasts max(1, COOLDOWN_FRAMES) frames.
  - missileHit is ignored.
- plrHit (synchronous, highest priority):
  - Next state is IDLE; fireReq, counter, and missile position clear to 0.
  - shotFired is 0 in that cycle.
- Priority per cycle: plrHit > missileHit > startOfFrame movement/launch.
- Position outputs hold their last value outside FLYING; consumers qualify them with missileActive.
- Arithmetic: 11-bit unsigned positions. The subtraction never underflows because of the compare/clamp rules above. The counter is sized for COOLDOWN_FRAMES up to 255.

## Timing
- All outputs are registered; reset values are all 0 (missileActive=0, shotFired=0, missileTopLeftX=0, missileTopLeftY=0).
- Launch:
  - missileActive, position, and shotFired become valid the cycle after the startOfFrame that launched.
  - Player position is sampled in the launch cycle.
- Movement: the Y update is visible the cycle after startOfFrame.
- Retirement:
  - missileActive drops the cycle after missileHit, or after the startOfFrame where Y < Y_SPEED.
  - Maximum missile count is 1.
- fireEdge in the same cycle as startOfFrame in IDLE launches immediately.
- Reset mid-flight: outputs clear asynchronously on resetN low; the block restarts in IDLE.

## Test plan
- Launch position: player at (320,450), fire edge, then startOfFrame → next cycle missileActive=1, X=348, Y=434, shotFired high for exactly 1 cycle.
- Flight and exit: launch from Y=434, 54 frames → Y=2. Next frame (2<8) → missileActive=0. After 4 further frames → IDLE; an earlier fire edge does not launch.
- Hit vs move: missileHit and startOfFrame in the same cycle at Y=200 → missileActive=0, Y stays 200, state COOLDOWN.
- Pending and ignored requests:
  - Fire edge mid-frame in IDLE → launch at the next startOfFrame.
  - Fire edge while FLYING, with the key held afterward → no second launch after COOLDOWN until a new edge.
- Clamp: player Y=10, launch → missile Y=0. Next startOfFrame → retire.
- Abort: plrHit during FLYING, and separately during COOLDOWN → next cycle missileActive=0, positions 0, IDLE. A new fire edge plus startOfFrame launches normally.
